rr_req_arbiter: RTL and testbench
=================================

Name: rr_req_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource between N requesters.
- Each requester holds a level request. The arbiter grants one requester at a time and holds that grant until the requester releases or a hold-limit expires.
- Also exports the OR-reduction of all requests as a "resource wanted" flag for power and clock-gate logic upstream of the shared datapath.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive cycles a grant may be held while another requester is waiting; 0 disables preemption.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  level request per requester; bit i = requester i.
- gnt  output  N  one-hot grant, registered; all-zero when no grant.
- gnt_valid  output  1  registered; high when gnt is non-zero.
- gnt_id  output  $clog2(N)  registered index of granted requester; 0 when gnt_valid=0.
- any_req  output  1  combinational OR of all req bits.
- preempt  output  1  registered one-cycle pulse when a grant was revoked by hold-limit.

Behaviour:
- Reset (rst=1 at an edge) sets the following, overriding any in-flight grant: gnt=0, gnt_valid=0, gnt_id=0, preempt=0, hold counter=0, last pointer=N-1, state=IDLE. Requester 0 therefore has highest priority after reset.
- any_req = |req at all times, including during reset.
- Arbitration order: search starts at last+1 and wraps modulo N. The first set bit in the search set wins.
- States: IDLE, GRANT.
- IDLE:
  - If any_req, next edge: state=GRANT, gnt=onehot(winner), gnt_id=winner, gnt_valid=1, hold=1.
  - Latency from req rising to gnt is 1 clock.
  - Otherwise remain IDLE with all outputs 0.
- GRANT, release (req[gnt_id]=0): at the next edge, last=gnt_id and re-arbitration runs over req with bit gnt_id masked.
  - If a winner exists: move straight to the new grant, stay in GRANT, hold=1. This gives back-to-back grants with no idle cycle.
  - If no winner: state=IDLE, outputs cleared.
- GRANT, still held: hold increments, saturating at MAX_HOLD.
  - If MAX_HOLD≠0, hold==MAX_HOLD and any other req bit is set: next edge revokes the grant. last=gnt_id, the new winner is granted from the masked set, hold=1, and preempt=1 for exactly that one cycle.
  - If no other requester is waiting, the grant holds indefinitely.
- Release and preemption condition in the same cycle: treated as release; preempt stays 0.
- A released or preempted requester re-enters normal round-robin and gets no immediate re-grant while others wait.
- gnt is always one-hot or zero; gnt_valid == |gnt; gnt_id is consistent with gnt.
- Requests that appear or disappear on non-granted bits have no effect until the next arbitration.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, GRANT}.
  - default constants ARB_N=4 and ARB_MAX_HOLD=8.
  - index-width function clog2.
- Sub-module rr_pick (purely combinational):
  - inputs: req[N], mask_idx, mask_en, last.
  - outputs: found, winner index.
  - rr_req_arbiter instantiates it once.

Test Plan (N=4, MAX_HOLD=8):
- Reset, then idle: rst high 2 cycles, then req=0000 for 5 cycles -> gnt=0000, gnt_valid=0, gnt_id=0, any_req=0, preempt=0 throughout.
- Single request, 1-cycle latency and release: req=0100 at cycle 0 -> gnt=0100, gnt_id=2 at cycle 1. Drop req at cycle 4 -> gnt=0000 at cycle 5.
- Fairness: req=1111 held, each grantee drops its req 1 cycle after being granted, then re-asserts -> grant order 0,1,2,3,0. Back-to-back handoff with no gnt=0 gap.
- Preemption: req=0011 held continuously -> requester 0 granted cycle 1. Requester 1 granted cycle 9 with preempt=1 only on cycle 9. Requester 0 regranted cycle 17.
- No preemption without contention: req=0001 held 20 cycles -> gnt=0001 continuously, preempt never asserts.
- Reset mid-grant: gnt=1000 active, assert rst one cycle with req=1111 -> next edge all outputs 0. After rst falls, requester 0 granted first.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin request arbiter.
//   arb_state_t  : arbiter FSM state encoding
//   ARB_N        : default number of requesters
//   ARB_MAX_HOLD : default hold limit under contention (0 = never preempt)
//   clog2()      : index width helper, never returns less than 1
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_N        = 4;
    localparam int ARB_MAX_HOLD = 8;

    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search.
//   req      : request vector, bit i = requester i
//   mask_idx : requester excluded from the search when mask_en is set
//   mask_en  : enables the exclusion of mask_idx
//   last     : search starts at last+1 and wraps modulo N
//   found    : at least one eligible request exists
//   winner   : index of the first eligible request in search order
import arb_pkg::*;

module rr_pick #(
    parameter  int N  = ARB_N,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] mask_idx,
    input  logic          mask_en,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] winner
);

    int idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        // Offsets 1..N visit every requester once, last itself being the final one.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx] && !(mask_en && (mask_idx == IW'(idx)))) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter sharing one downstream resource between N requesters.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   req       : level request per requester
//   gnt       : registered one-hot grant, zero when nothing granted
//   gnt_valid : registered, high when gnt is non-zero
//   gnt_id    : registered index of the granted requester, 0 when idle
//   any_req   : combinational OR of all requests (resource wanted)
//   preempt   : one-cycle pulse when a grant was revoked by the hold limit
//
// state | meaning
// IDLE  | no grant outstanding, arbitrate over all requests
// GRANT | gnt_id owns the resource; hand off on release or hold-limit expiry
import arb_pkg::*;

module rr_req_arbiter #(
    parameter  int N        = ARB_N,
    parameter  int MAX_HOLD = ARB_MAX_HOLD,
    localparam int IW       = clog2(N),
    localparam int HW       = clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id,
    output logic          any_req,
    output logic          preempt
);

    arb_state_t    state;
    logic [HW-1:0] hold;
    logic [IW-1:0] last;

    logic          found;
    logic [IW-1:0] winner;
    logic          in_grant;

    assign any_req  = |req;
    assign in_grant = (state == GRANT);

    // While granting, the current owner is excluded and the search starts just
    // after it, which is exactly where last will point after the handoff.
    rr_pick #(.N(N)) u_pick (
        .req      (req),
        .mask_idx (gnt_id),
        .mask_en  (in_grant),
        .last     (in_grant ? gnt_id : last),
        .found    (found),
        .winner   (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            preempt   <= 1'b0;
            hold      <= '0;
            last      <= IW'(N - 1);
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= GRANT;
                        gnt       <= N'(1) << winner;
                        gnt_valid <= 1'b1;
                        gnt_id    <= winner;
                        hold      <= HW'(1);
                    end
                end
                GRANT: begin
                    if (!req[gnt_id]) begin
                        last <= gnt_id;
                        if (found) begin
                            gnt    <= N'(1) << winner;
                            gnt_id <= winner;
                            hold   <= HW'(1);
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            gnt_valid <= 1'b0;
                            gnt_id    <= '0;
                            hold      <= '0;
                        end
                    end else if ((MAX_HOLD != 0) && (hold == HW'(MAX_HOLD)) && found) begin
                        last    <= gnt_id;
                        gnt     <= N'(1) << winner;
                        gnt_id  <= winner;
                        hold    <= HW'(1);
                        preempt <= 1'b1;
                    end else if ((MAX_HOLD != 0) && (hold != HW'(MAX_HOLD))) begin
                        hold <= hold + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_req_arbiter.sv
module tb_rr_req_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 8;
    localparam int IW   = 2;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
    logic          any_req;
    logic          preempt;

    int n_checks;
    int n_pass;

    // Reference model: who owns the resource, where the rotation stands, and
    // how many consecutive cycles the owner has held it.
    int m_owner;
    int m_last;
    int m_hold;
    bit m_preempt;

    rr_req_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .any_req   (any_req),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First requester after 'start' (wrapping) that is requesting and not 'excl'.
    function automatic int next_in_rotation(input logic [N-1:0] r, input int start, input int excl);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (start + k) % N;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] one;
        one = 1;
        return (m_owner < 0) ? '0 : (one << m_owner);
    endfunction

    function automatic logic [IW-1:0] exp_id();
        return (m_owner < 0) ? '0 : IW'(m_owner);
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return at negedge.
    task automatic step(input logic [N-1:0] r, input logic rs);
        int w;
        req = r;
        rst = rs;
        @(posedge clk);
        m_preempt = 1'b0;
        if (rs) begin
            m_owner = -1;
            m_last  = N - 1;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            w = next_in_rotation(r, m_last, -1);
            if (w >= 0) begin
                m_owner = w;
                m_hold  = 1;
            end
        end else if (!r[m_owner]) begin
            m_last  = m_owner;
            m_owner = next_in_rotation(r, m_owner, m_owner);
            m_hold  = (m_owner >= 0) ? 1 : 0;
        end else begin
            w = next_in_rotation(r, m_owner, m_owner);
            if (MAXH != 0 && m_hold >= MAXH && w >= 0) begin
                m_last    = m_owner;
                m_owner   = w;
                m_hold    = 1;
                m_preempt = 1'b1;
            end else if (m_hold < MAXH) begin
                m_hold = m_hold + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step('0, 1'b1);
        step('0, 1'b1);
        n_checks++;
        if ({gnt, gnt_valid, gnt_id, preempt, any_req} !== 9'b0)
            $display("FAIL reset_outputs: got gnt=%b v=%b id=%0d pre=%b any=%b, expected all 0",
                     gnt, gnt_valid, gnt_id, preempt, any_req);
        else n_pass++;
        req = 4'b1010;
        #1;
        n_checks++;
        if (any_req !== 1'b1)
            $display("FAIL reset_any_req: got %b expected 1 while rst high", any_req);
        else n_pass++;
        req = '0;
    endtask

    task automatic test_idle();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step('0, 1'b0);
            n_checks++;
            if ({gnt, gnt_valid, gnt_id, preempt, any_req} !== 9'b0)
                $display("FAIL idle_outputs cyc%0d: got gnt=%b v=%b id=%0d pre=%b any=%b, expected all 0",
                         c, gnt, gnt_valid, gnt_id, preempt, any_req);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        for (int c = 1; c <= 4; c++) begin
            step(4'b0100, 1'b0);
            n_checks++;
            if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_valid !== 1'b1)
                $display("FAIL single_grant cyc%0d: got gnt=%b id=%0d v=%b, expected 0100/2/1",
                         c, gnt, gnt_id, gnt_valid);
            else n_pass++;
        end
        step('0, 1'b0);
        n_checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0)
            $display("FAIL single_release: got gnt=%b v=%b id=%0d, expected 0000/0/0",
                     gnt, gnt_valid, gnt_id);
        else n_pass++;
    endtask

    task automatic test_fairness();
        int cur;
        step('0, 1'b1);
        step(4'b1111, 1'b0);
        n_checks++;
        if (gnt !== 4'b0001)
            $display("FAIL fair_first: got gnt=%b expected 0001", gnt);
        else n_pass++;
        cur = 0;
        for (int k = 1; k <= 4; k++) begin
            step(4'b1111 & ~(4'b0001 << cur), 1'b0);
            cur = (cur + 1) % N;
            n_checks++;
            if (gnt !== (4'b0001 << cur) || gnt_valid !== 1'b1 || gnt_id !== IW'(cur))
                $display("FAIL fair_order step%0d: got gnt=%b v=%b id=%0d, expected id %0d",
                         k, gnt, gnt_valid, gnt_id, cur);
            else n_pass++;
        end
    endtask

    task automatic test_preempt();
        logic [N-1:0] eg;
        logic         ep;
        step('0, 1'b1);
        for (int c = 1; c <= 17; c++) begin
            step(4'b0011, 1'b0);
            eg = (((c - 1) / MAXH) % 2 == 0) ? 4'b0001 : 4'b0010;
            ep = (c > 1) && ((c - 1) % MAXH == 0);
            n_checks++;
            if (gnt !== eg || preempt !== ep)
                $display("FAIL preempt_seq cyc%0d: got gnt=%b pre=%b, expected gnt=%b pre=%b",
                         c, gnt, preempt, eg, ep);
            else n_pass++;
        end
    endtask

    task automatic test_no_preempt();
        step('0, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            step(4'b0001, 1'b0);
            n_checks++;
            if (gnt !== 4'b0001 || preempt !== 1'b0)
                $display("FAIL solo_hold cyc%0d: got gnt=%b pre=%b, expected 0001/0", c, gnt, preempt);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_grant();
        step('0, 1'b1);
        step(4'b1000, 1'b0);
        n_checks++;
        if (gnt !== 4'b1000)
            $display("FAIL midrst_setup: got gnt=%b expected 1000", gnt);
        else n_pass++;
        step(4'b1111, 1'b1);
        n_checks++;
        if ({gnt, gnt_valid, gnt_id, preempt} !== 8'b0)
            $display("FAIL midrst_clear: got gnt=%b v=%b id=%0d pre=%b, expected all 0",
                     gnt, gnt_valid, gnt_id, preempt);
        else n_pass++;
        step(4'b1111, 1'b0);
        n_checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0)
            $display("FAIL midrst_first: got gnt=%b id=%0d, expected 0001/0", gnt, gnt_id);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic         rs;
        logic [8:0]   got;
        logic [8:0]   exp_v;
        r = '0;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            rs = ($urandom_range(99) == 0);
            step(r, rs);
            got   = {gnt, gnt_valid, gnt_id, preempt, any_req};
            exp_v = {exp_gnt(), (m_owner >= 0), exp_id(), m_preempt, |r};
            n_checks++;
            if (got !== exp_v)
                $display("FAIL random_model cyc%0d req=%b: got {gnt,v,id,pre,any}=%b expected %b",
                         c, r, got, exp_v);
            else n_pass++;
            n_checks++;
            if (!$onehot0(gnt) || gnt_valid !== (|gnt))
                $display("FAIL random_onehot cyc%0d: got gnt=%b v=%b", c, gnt, gnt_valid);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        m_owner   = -1;
        m_last    = N - 1;
        m_hold    = 0;
        m_preempt = 1'b0;
        req       = '0;
        rst       = 1'b1;

        test_reset();
        test_idle();
        test_single();
        test_fairness();
        test_preempt();
        test_no_preempt();
        test_reset_mid_grant();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
